// File: rtl/lb_uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the default frame shape used by both the transmitter and the receiver.
package lb_uart_pkg;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned MID_SAMPLE    = 7;
  localparam int unsigned TICK_W        = $clog2(OVERSAMPLE);

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_PARITY_EN = 1;
  localparam int unsigned DEF_STOP_BITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/lb_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 so an
// idle-high line reads as idle straight out of reset.
module lb_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lb_uart_rx.sv
// UART receiver: 16x oversampled deserialiser with even-parity and framing
// checks, feeding a one-deep holding buffer read through a rdy/rd handshake.
module lb_uart_rx
  import lb_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN = DEF_PARITY_EN,
  parameter int unsigned STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + STOP_BITS);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID_SAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  rx_state_t            state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 armed, armed_nxt;
  logic                 commit_c;
  logic                 rx_s;

  lb_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Next-state, counter and sampling logic; everything advances on baud_tick only
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    armed_nxt = armed;
    commit_c  = 1'b0;

    if (state == IDLE && rx_s) armed_nxt = 1'b1;

    if (baud_tick) begin
      tick_nxt = tick_cnt + TICK_W'(1);
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
            perr_nxt  = 1'b0;
            ferr_nxt  = 1'b0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + BIT_W'(1);
            if (bit_cnt == DATA_LAST) begin
              bit_nxt   = '0;
              state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            perr_nxt  = (^shreg) ^ rx_s;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            if (!rx_s) ferr_nxt = 1'b1;
            bit_nxt = bit_cnt + BIT_W'(1);
            // Re-arm only if the final stop bit was high, so a held break cannot retrigger
            if (bit_cnt == STOP_LAST) begin
              commit_c  = 1'b1;
              state_nxt = IDLE;
              armed_nxt = rx_s;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      armed      <= 1'b0;
      data_out   <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      perr     <= perr_nxt;
      ferr     <= ferr_nxt;
      armed    <= armed_nxt;
      busy     <= (state_nxt != IDLE);

      // Commit beats a same-cycle read: buffer stays full, no overrun recorded
      if (commit_c) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= ferr_nxt;
        rdy        <= 1'b1;
        overrun    <= (rd && rdy) ? 1'b0 : (overrun | rdy);
      end else if (rd && rdy) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lb_uart_rx.sv
// Directed bench for lb_uart_rx: 8E2 frames with baud_tick every other clock,
// so one bit time is 32 clocks.
module tb_lb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data_out;
  logic       rdy, parity_err, frame_err, overrun, busy;

  int checks = 0;
  int passed = 0;
  int tick_count = 0;

  lb_uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rd         (rd),
    .data_out   (data_out),
    .rdy        (rdy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe on every other clock, changed just after the rising edge
  initial forever begin
    @(posedge clk);
    #1 baud_tick = ~baud_tick;
  end

  initial forever begin
    @(posedge clk);
    if (baud_tick) tick_count++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Drives one frame bit by bit, leaving the line at idle_level afterwards
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input logic idle_level);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (32) @(negedge clk);
    end
    rx = p;
    repeat (32) @(negedge clk);
    rx = s1;
    repeat (32) @(negedge clk);
    rx = s2;
    repeat (32) @(negedge clk);
    rx = idle_level;
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h exp 00", data_out); else passed++;
    checks++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b exp 0", rdy); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b exp 0", parity_err); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b exp 0", frame_err); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", overrun); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    int det = -1;
    int com = -1;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 40 && det < 0; n++) begin
          @(negedge clk);
          if (busy) det = tick_count;
        end
        for (int n = 0; n < 500 && det >= 0 && com < 0; n++) begin
          @(negedge clk);
          if (rdy) com = tick_count;
        end
      end
    join
    checks++; if (com - det != 184) $display("FAIL basic_latency: got %0d ticks exp 184", com - det); else passed++;
    checks++; if (rdy !== 1'b1) $display("FAIL basic_rdy: got %b exp 1", rdy); else passed++;
    checks++; if (data_out !== 8'hA5) $display("FAIL basic_data: got %h exp a5", data_out); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL basic_perr: got %b exp 0", parity_err); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL basic_ferr: got %b exp 0", frame_err); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b exp 0", overrun); else passed++;
    repeat (4) @(negedge clk);
    do_read();
    checks++; if (rdy !== 1'b0) $display("FAIL basic_rd_clears: got %b exp 0", rdy); else passed++;
    checks++; if (data_out !== 8'hA5) $display("FAIL basic_data_hold: got %h exp a5", data_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b exp 0", busy); else passed++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (parity_err !== 1'b1) $display("FAIL parity_err: got %b exp 1", parity_err); else passed++;
    checks++; if (data_out !== 8'h01) $display("FAIL parity_data: got %h exp 01", data_out); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL parity_ferr: got %b exp 0", frame_err); else passed++;
    do_read();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_break();
    logic saw_busy = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (frame_err !== 1'b1) $display("FAIL break_ferr: got %b exp 1", frame_err); else passed++;
    checks++; if (data_out !== 8'h3C) $display("FAIL break_data: got %h exp 3c", data_out); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL break_perr: got %b exp 0", parity_err); else passed++;
    do_read();
    for (int n = 0; n < 160; n++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0) $display("FAIL break_no_retrigger: got busy %b exp 0", saw_busy); else passed++;
    checks++; if (rdy !== 1'b0) $display("FAIL break_no_frame: got rdy %b exp 0", rdy); else passed++;
    rx = 1'b1;
    repeat (64) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (rdy !== 1'b1) $display("FAIL break_rearm_rdy: got %b exp 1", rdy); else passed++;
    checks++; if (data_out !== 8'h5A) $display("FAIL break_rearm_data: got %h exp 5a", data_out); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL break_rearm_ferr: got %b exp 0", frame_err); else passed++;
    do_read();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b exp 1", busy); else passed++;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_idle: got %b exp 0", busy); else passed++;
    checks++; if (rdy !== 1'b0) $display("FAIL glitch_rdy: got %b exp 0", rdy); else passed++;
    checks++; if (data_out !== 8'h5A) $display("FAIL glitch_data: got %h exp 5a", data_out); else passed++;
  endtask

  task automatic test_overrun();
    int  det = -1;
    logic hit = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (16) @(negedge clk);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (data_out !== 8'h22) $display("FAIL ovr_data: got %h exp 22", data_out); else passed++;
    checks++; if (rdy !== 1'b1) $display("FAIL ovr_rdy: got %b exp 1", rdy); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b exp 1", overrun); else passed++;
    do_read();
    checks++; if (rdy !== 1'b0) $display("FAIL ovr_rd_rdy: got %b exp 0", rdy); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_rd_clear: got %b exp 0", overrun); else passed++;
    repeat (16) @(negedge clk);

    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (16) @(negedge clk);
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
      begin
        for (int n = 0; n < 40 && det < 0; n++) begin
          @(negedge clk);
          if (busy) det = tick_count;
        end
        // Next rising edge carries the 184th tick after start detection
        for (int n = 0; n < 500 && det >= 0 && !hit; n++) begin
          @(negedge clk);
          if (tick_count == det + 183 && baud_tick) begin
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    checks++; if (hit !== 1'b1) $display("FAIL ovr_commit_rd_timing: got %b exp 1", hit); else passed++;
    checks++; if (rdy !== 1'b1) $display("FAIL ovr_commit_rd_rdy: got %b exp 1", rdy); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_commit_rd_overrun: got %b exp 0", overrun); else passed++;
    checks++; if (data_out !== 8'h22) $display("FAIL ovr_commit_rd_data: got %h exp 22", data_out); else passed++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b exp 1", busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b0) $display("FAIL rstmid_rdy: got %b exp 0", rdy); else passed++;
    checks++; if (data_out !== 8'h00) $display("FAIL rstmid_data: got %h exp 00", data_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b exp 0", overrun); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL rstmid_perr: got %b exp 0", parity_err); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %b exp 0", frame_err); else passed++;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (rdy !== 1'b1) $display("FAIL rstmid_next_rdy: got %b exp 1", rdy); else passed++;
    checks++; if (data_out !== 8'h7E) $display("FAIL rstmid_next_data: got %h exp 7e", data_out); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL rstmid_next_perr: got %b exp 0", parity_err); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rstmid_next_ferr: got %b exp 0", frame_err); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_false_start();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lb_uart_rx.md
# lb_uart_rx

Serial receiver for the UART link on the PicoBlaze SoC, and the receive-side counterpart of the 12-bit transmit shift register: it deserialises frames of 1 start bit, 8 data bits (LSB first), 1 even-parity bit and 2 stop bits. The line idles high. The receiver samples the line with a 16x oversampling tick, checks parity and framing, and holds each received byte in a one-deep buffer. The PicoBlaze port logic reads the buffer through a ready/read handshake.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame.
- PARITY_EN, 1, 1 = even-parity bit present after the data bits; 0 = no parity bit.
- STOP_BITS, 2, number of stop bits checked (1 or 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle strobe at 16x the baud rate.
- rx  input  1  asynchronous serial line, idle high.
- rd  input  1  one-cycle read strobe; clears rdy.
- data_out  output  DATA_BITS  last received byte; holds until the next frame completes.
- rdy  output  1  buffer holds an unread byte.
- parity_err  output  1  parity mismatch on the byte in data_out.
- frame_err  output  1  a stop bit sampled low on the byte in data_out.
- overrun  output  1  sticky: a frame completed while rdy=1; cleared by rd.
- busy  output  1  high in every state except IDLE.

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1) to give rx_s.
- All sampling logic advances only on cycles where baud_tick=1. The 4-bit tick counter is tick_cnt and the bit counter is bit_cnt.
- IDLE
  - Requires armed=1, which is set when rx_s=1 has been seen.
  - On rx_s=0 with armed=1: go to START, set tick_cnt=0.
- START
  - At tick_cnt=7 (mid-bit), if rx_s=1 this is a false start: return to IDLE and capture nothing.
  - If rx_s=0: set tick_cnt=0 and bit_cnt=0, then go to DATA.
- DATA
  - Every 16 ticks (tick_cnt=15), shift rx_s into the MSB of shreg, shifting right, so the first received bit ends up as bit 0.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY
  - At tick_cnt=15, sample p. perr = (^shreg) ^ p, so even parity over data plus the parity bit.
- STOP
  - Sample STOP_BITS times at 16-tick intervals. ferr is set if any sample is 0.
  - After the last sample, in the same cycle, perform the commit:
    - data_out <= shreg.
    - parity_err <= perr (0 if PARITY_EN=0).
    - frame_err <= ferr.
    - rdy <= 1.
    - overrun is set if rdy was already 1 and no rd occurs that cycle.
    - State returns to IDLE.
    - armed <= rx_s (this is the last stop sample), so a break condition holding the line low cannot retrigger a frame.
- rd clears rdy and overrun. rd while rdy=0 has no effect.
- rd and commit in the same cycle: commit wins. rdy stays 1 and overrun is not set.
- Reset mid-frame aborts the frame. Nothing is committed.

## Timing
- Reset values:
  - data_out=0.
  - rdy=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - State IDLE, armed=0, synchronizer flops=1.
- Start detection latency is 2 clk (synchronizer) plus up to 1 baud_tick.
- Commit occurs on the clk edge of the tick that samples the final stop bit. That is 16*(1+DATA_BITS+PARITY_EN+STOP_BITS)-8 ticks after the tick that detected start, which is 184 ticks for the defaults.
- rdy, data_out and the error flags all update on the same edge.
- rd takes effect on the next edge.
- baud_tick may be high on consecutive cycles. Each high cycle counts as one tick.

## Structure
- Package lb_uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - OVERSAMPLE=16 and MID_SAMPLE=7;
  - the default frame parameters, shared with the transmitter.
- Sub-module lb_sync_2ff is the reset-to-1 two-flop synchronizer, reusable for other async inputs.
- The FSM, counters, shift register and holding buffer stay in lb_uart_rx.

## Test plan
- Send byte 0xA5 with correct parity (p=0) and 2 high stop bits.
  - Required: rdy=1, data_out=0xA5, parity_err=0, frame_err=0 at the 184th tick after start detection.
  - A subsequent rd clears rdy.
- Send 0x01 with parity bit 0.
  - Required: parity_err=1, data_out=0x01.
- Send 0x3C with the second stop bit low, then hold rx low for 5 bit times.
  - Required: frame_err=1.
  - No second frame is received until rx returns high and then falls again.
- Drive a 4-tick low glitch on an idle line.
  - Required: false start, busy returns to 0, rdy stays 0.
- Receive 0x11 without issuing rd, then receive 0x22.
  - Required: data_out=0x22 and overrun=1.
  - Repeat with rd asserted on the exact commit cycle of 0x22: required rdy=1, overrun=0.
- Assert reset in the middle of DATA.
  - Required: next cycle all outputs at reset values. The following clean frame 0x7E is received correctly.
